alu_issue_stage: RTL

- Decode-side initiator for the pipelined core's 64-bit integer ALU.
- Decodes a 32-bit RV64I instruction plus register-file operands into the ALU request: funct3, funct7, op_a, op_b, rd, reg_write.
- Holds the request in a 2-entry valid/ready skid buffer between ID and EX, giving full throughput under back-pressure.
- Payloads always use the encodings the ALU accepts; load/store/LUI are mapped to add.

---
 rtl/alu_issue_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ID-side issue stage for the 64-bit integer ALU: decodes RV64I ALU/load/store/LUI
// instructions into ALU requests and buffers them in a 2-entry valid/ready skid buffer.
module alu_issue_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [XLEN-1:0]  op_a,
    output logic [XLEN-1:0]  op_b,
    output logic [4:0]       rd_addr,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_count
);

    typedef struct packed {
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [4:0]      rd;
        logic            reg_write;
        logic            illegal;
    } req_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_reg, state_next;
    req_t             main_reg, skid_reg, dec;
    logic             in_ready_reg;
    logic [CNT_W-1:0] issued_count_reg;
    logic             in_fire, out_fire;
    logic             main_from_in, main_from_skid, skid_from_in;
    logic             legal, is_store;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             unused_rs1_field;

    // The rs1 index field is resolved by the register file before this stage.
    assign unused_rs1_field = ^instr[19:15];

    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        dec      = '0;
        legal    = 1'b1;
        is_store = 1'b0;
        dec.rd   = instr[11:7];
        case (instr[6:0])
            7'b0110011: begin
                dec.funct3 = f3;
                dec.funct7 = f7;
                dec.op_a   = rs1_data;
                dec.op_b   = rs2_data;
                legal      = (f7 == 7'b0000000) ||
                             (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            7'b0010011: begin
                dec.funct3 = f3;
                dec.op_a   = rs1_data;
                dec.op_b   = {{(XLEN-12){instr[31]}}, instr[31:20]};
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.op_b = {{(XLEN-6){1'b0}}, instr[25:20]};
                    if (instr[31:26] == 6'b010000 && f3 == 3'b101)
                        dec.funct7 = 7'b0100000;
                    else if (instr[31:26] != 6'b000000)
                        legal = 1'b0;
                end
            end
            7'b0000011: begin
                dec.op_a = rs1_data;
                dec.op_b = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                is_store = 1'b1;
                dec.rd   = 5'd0;
                dec.op_a = rs1_data;
                dec.op_b = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b0110111: begin
                dec.op_b = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        // Illegal requests carry a neutral payload so the ALU never sees a bad encoding.
        if (!legal) begin
            dec.funct3 = 3'b000;
            dec.funct7 = 7'b0000000;
            dec.op_a   = '0;
            dec.op_b   = '0;
        end
        dec.illegal   = !legal;
        dec.reg_write = legal && !is_store && (dec.rd != 5'd0);
    end

    assign in_fire  = in_valid && in_ready_reg;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != FULL);
        end
    end

    always_comb begin
        state_next     = state_reg;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: if (in_fire) begin
                    state_next   = ONE;
                    main_from_in = 1'b1;
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_next   = FULL;
                        skid_from_in = 1'b1;
                    end else if (in_fire && out_fire) begin
                        main_from_in = 1'b1;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: if (out_fire) begin
                    state_next     = ONE;
                    main_from_skid = 1'b1;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_reg != EMPTY);
        in_ready  = in_ready_reg;
        funct3    = main_reg.funct3;
        funct7    = main_reg.funct7;
        op_a      = main_reg.op_a;
        op_b      = main_reg.op_b;
        rd_addr   = main_reg.rd;
        reg_write = main_reg.reg_write;
        illegal   = main_reg.illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            if (main_from_in)
                main_reg <= dec;
            else if (main_from_skid)
                main_reg <= skid_reg;
            if (skid_from_in)
                skid_reg <= dec;
        end
    end

    // A handshake in a flush cycle has already left the stage, so it still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            issued_count_reg <= '0;
        else if (out_fire)
            issued_count_reg <= issued_count_reg + 1'b1;
    end

    assign issued_count = issued_count_reg;

endmodule
